// File: rtl/ci_issuer.sv
// -----------------------------------------------------------------------------
// ci_issuer
//
// Initiator side of the custom-instruction (CI) interface. Accepts one request
// at a time, fires a single-cycle start pulse at the responder, waits a bounded
// number of cycles for done, then holds the captured result (or a timeout
// indication) on a valid/ready response port until the consumer takes it.
//
// Parameters
//   TIMEOUT_CYCLES  WAIT cycles without done before aborting (1..255)
//
// Ports
//   clock, nReset                 clock / asynchronous active-low reset
//   reqValid, reqReady            request handshake
//   reqCiN, reqValueA, reqValueB  request payload
//   ciStart                       one-cycle start pulse to the responder
//   ciCiN, ciValueA, ciValueB     operands to the responder (0 when idle)
//   ciDone, ciResult              responder completion and result
//   respValid, respReady          response handshake
//   respResult, respTimeout       captured result and timeout flag
// -----------------------------------------------------------------------------
module ci_issuer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        nReset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [7:0]  reqCiN,
    input  logic [31:0] reqValueA,
    input  logic [31:0] reqValueB,
    output logic        ciStart,
    output logic [7:0]  ciCiN,
    output logic [31:0] ciValueA,
    output logic [31:0] ciValueB,
    input  logic        ciDone,
    input  logic [31:0] ciResult,
    output logic        respValid,
    input  logic        respReady,
    output logic [31:0] respResult,
    output logic        respTimeout
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [1:0]  state_reg,   state_next;
    logic [7:0]  count_reg,   count_next;
    logic [7:0]  cin_reg,     cin_next;
    logic [31:0] a_reg,       a_next;
    logic [31:0] b_reg,       b_next;
    logic [31:0] result_reg,  result_next;
    logic        timeout_reg, timeout_next;

    // Cleared by reset and set on the first clock edge afterwards, so that
    // reqReady stays low for as long as reset is held and rises only once the
    // block is actually clocking.
    logic        alive_reg;

    logic [7:0]  count_inc;
    logic        bus_active;
    logic        accept;

    assign count_inc  = count_reg + 8'd1;
    assign bus_active = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT);
    assign accept     = reqValid && reqReady;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        cin_next     = cin_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        result_next  = result_reg;
        timeout_next = timeout_reg;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    cin_next   = reqCiN;
                    a_next     = reqValueA;
                    b_next     = reqValueB;
                    state_next = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                // A combinational responder can answer in the start cycle.
                if (ciDone) begin
                    result_next  = ciResult;
                    timeout_next = 1'b0;
                    state_next   = ST_RESP;
                end else begin
                    count_next = 8'd0;
                    state_next = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // done is checked first so that it wins over the final count.
                if (ciDone) begin
                    result_next  = ciResult;
                    timeout_next = 1'b0;
                    state_next   = ST_RESP;
                end else begin
                    count_next = count_inc;
                    if (count_inc == TIMEOUT_LIMIT) begin
                        result_next  = 32'd0;
                        timeout_next = 1'b1;
                        state_next   = ST_RESP;
                    end
                end
            end

            ST_RESP: begin
                if (respReady) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_reg   <= ST_IDLE;
            count_reg   <= 8'd0;
            cin_reg     <= 8'd0;
            a_reg       <= 32'd0;
            b_reg       <= 32'd0;
            result_reg  <= 32'd0;
            timeout_reg <= 1'b0;
            alive_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            cin_reg     <= cin_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            result_reg  <= result_next;
            timeout_reg <= timeout_next;
            alive_reg   <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign reqReady    = alive_reg && (state_reg == ST_IDLE);
    assign ciStart     = (state_reg == ST_ISSUE);
    assign respValid   = (state_reg == ST_RESP);
    assign respResult  = result_reg;
    assign respTimeout = timeout_reg;

    // Operands are only shown while an operation is in flight; the bus is
    // forced to zero otherwise so responders never see stale values.
    assign ciCiN    = bus_active ? cin_reg : 8'd0;
    assign ciValueA = bus_active ? a_reg   : 32'd0;
    assign ciValueB = bus_active ? b_reg   : 32'd0;

endmodule

// File: tb/tb_ci_issuer.sv
// -----------------------------------------------------------------------------
// tb_ci_issuer
//
// Drives two ci_issuer instances (default timeout and a 4-cycle timeout) from a
// shared stimulus set, with a programmable responder model, a directed vector
// table, hand-written reset / spurious-done sequences and randomized traffic
// checked against a latency/result reference model.
// -----------------------------------------------------------------------------
module tb_ci_issuer;

    localparam logic [7:0] RSP_ID = 8'd30;

    logic clock  = 1'b0;
    logic nReset = 1'b0;
    always #5 clock = ~clock;

    // Shared stimulus; sel4 picks the TIMEOUT_CYCLES=4 instance.
    logic        sel4       = 1'b0;
    logic        req_valid  = 1'b0;
    logic [7:0]  req_cin    = 8'd0;
    logic [31:0] req_a      = 32'd0;
    logic [31:0] req_b      = 32'd0;
    logic        resp_ready = 1'b1;

    // Per-instance wiring
    logic [1:0]  req_valid_w;
    logic [1:0]  req_ready_w;
    logic [1:0]  ci_start_w;
    logic [7:0]  ci_cin_w [2];
    logic [31:0] ci_a_w [2];
    logic [31:0] ci_b_w [2];
    logic [1:0]  ci_done_w;
    logic [1:0]  resp_ready_w;
    logic [1:0]  resp_valid_w;
    logic [31:0] resp_result_w [2];
    logic [1:0]  resp_timeout_w;

    // Selected-instance view
    logic        req_ready, ci_start, resp_valid, resp_timeout;
    logic [7:0]  ci_cin;
    logic [31:0] ci_a, ci_b, resp_result;

    // Responder
    logic        ci_done;
    logic [31:0] ci_result;
    int          rsp_mode  = 0;
    int          rsp_delay = 0;
    logic        rsp_kill  = 1'b1;
    logic        spur_done = 1'b0;
    logic        pend      = 1'b0;
    int          pend_cnt  = 0;

    assign req_valid_w[0]  = req_valid && !sel4;
    assign req_valid_w[1]  = req_valid &&  sel4;
    assign ci_done_w[0]    = ci_done && !sel4;
    assign ci_done_w[1]    = ci_done &&  sel4;
    assign resp_ready_w[0] = sel4 ? 1'b1 : resp_ready;
    assign resp_ready_w[1] = sel4 ? resp_ready : 1'b1;

    assign req_ready    = sel4 ? req_ready_w[1]    : req_ready_w[0];
    assign ci_start     = sel4 ? ci_start_w[1]     : ci_start_w[0];
    assign ci_cin       = sel4 ? ci_cin_w[1]       : ci_cin_w[0];
    assign ci_a         = sel4 ? ci_a_w[1]         : ci_a_w[0];
    assign ci_b         = sel4 ? ci_b_w[1]         : ci_b_w[0];
    assign resp_valid   = sel4 ? resp_valid_w[1]   : resp_valid_w[0];
    assign resp_result  = sel4 ? resp_result_w[1]  : resp_result_w[0];
    assign resp_timeout = sel4 ? resp_timeout_w[1] : resp_timeout_w[0];

    ci_issuer #(.TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .nReset(nReset),
        .reqValid(req_valid_w[0]), .reqReady(req_ready_w[0]),
        .reqCiN(req_cin), .reqValueA(req_a), .reqValueB(req_b),
        .ciStart(ci_start_w[0]), .ciCiN(ci_cin_w[0]),
        .ciValueA(ci_a_w[0]), .ciValueB(ci_b_w[0]),
        .ciDone(ci_done_w[0]), .ciResult(ci_result),
        .respValid(resp_valid_w[0]), .respReady(resp_ready_w[0]),
        .respResult(resp_result_w[0]), .respTimeout(resp_timeout_w[0])
    );

    ci_issuer #(.TIMEOUT_CYCLES(4)) dut4 (
        .clock(clock), .nReset(nReset),
        .reqValid(req_valid_w[1]), .reqReady(req_ready_w[1]),
        .reqCiN(req_cin), .reqValueA(req_a), .reqValueB(req_b),
        .ciStart(ci_start_w[1]), .ciCiN(ci_cin_w[1]),
        .ciValueA(ci_a_w[1]), .ciValueB(ci_b_w[1]),
        .ciDone(ci_done_w[1]), .ciResult(ci_result),
        .respValid(resp_valid_w[1]), .respReady(resp_ready_w[1]),
        .respResult(resp_result_w[1]), .respTimeout(resp_timeout_w[1])
    );

    // Responder operation: mode 0 = absolute difference of the two low bytes
    // of A, mode 1 = A + B, mode 2 = constant 0xDEADBEEF.
    function automatic logic [31:0] ci_func(input int mode, input logic [31:0] a,
                                            input logic [31:0] b);
        int hi, lo;
        hi = int'(a[15:8]);
        lo = int'(a[7:0]);
        case (mode)
            0:       return (hi > lo) ? 32'(hi - lo) : 32'(lo - hi);
            1:       return a + b;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Responder: id RSP_ID; delay 0 answers combinationally on start,
    // delay d answers d cycles after the start cycle.
    always_comb begin
        ci_done   = spur_done;
        ci_result = 32'hA5A5_5A5A;
        if (ci_start && ci_cin == RSP_ID && rsp_delay == 0) ci_done = 1'b1;
        if (pend && pend_cnt == 0) ci_done = 1'b1;
        if (ci_done && !spur_done) ci_result = ci_func(rsp_mode, ci_a, ci_b);
    end

    always @(posedge clock) begin
        if (!nReset || rsp_kill) begin
            pend     <= 1'b0;
            pend_cnt <= 0;
        end else if (ci_start && ci_cin == RSP_ID && rsp_delay > 0) begin
            pend     <= 1'b1;
            pend_cnt <= rsp_delay - 1;
        end else if (pend) begin
            if (pend_cnt == 0) pend <= 1'b0;
            else               pend_cnt <= pend_cnt - 1;
        end
    end

    // -------------------------------------------------------------------------
    // Checking
    // -------------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    // Reference model: done lands in cycle 1+delay; WAIT spans cycles 2..N+1.
    task automatic model(input logic s4, input logic [7:0] cin, input logic [31:0] a,
                         input logic [31:0] b, input int mode, input int delay,
                         output int lat, output logic [31:0] res, output logic to);
        int n;
        n = s4 ? 4 : 16;
        if (cin == RSP_ID && delay <= n) begin
            lat = 2 + delay;
            res = ci_func(mode, a, b);
            to  = 1'b0;
        end else begin
            lat = n + 2;
            res = 32'd0;
            to  = 1'b0 | 1'b1;
        end
    endtask

    // Runs one operation starting at a negedge with the selected DUT idle;
    // returns at a negedge with the DUT idle again.
    task automatic run_op(input string tag, input logic s4, input logic [7:0] cin,
                          input logic [31:0] a, input logic [31:0] b, input int mode,
                          input int delay, input int hold, input int exp_lat,
                          input logic [31:0] exp_res, input logic exp_to);
        int lat, bad_start, bad_bus, bad_ready, bad_stab;
        logic [31:0] held_res;
        logic        held_to;
        lat = 0; bad_start = 0; bad_bus = 0; bad_ready = 0; bad_stab = 0;
        sel4 = s4; rsp_mode = mode; rsp_delay = delay; rsp_kill = 1'b0;
        resp_ready = (hold == 0);
        req_cin = cin; req_a = a; req_b = b; req_valid = 1'b1;
        #1;
        chk({tag, "_accept_ready"}, 32'(req_ready), 32'd1);
        @(negedge clock);
        req_valid = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (resp_valid === 1'b1) begin
                lat = cyc;
                break;
            end
            if (ci_start !== (cyc == 1)) bad_start++;
            if (ci_cin !== cin || ci_a !== a || ci_b !== b) bad_bus++;
            if (req_ready !== 1'b0) bad_ready++;
            @(negedge clock);
        end
        rsp_kill = 1'b1;
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_start_pulse"}, 32'(bad_start), 32'd0);
        chk({tag, "_bus_stable"}, 32'(bad_bus), 32'd0);
        chk({tag, "_busy_not_ready"}, 32'(bad_ready), 32'd0);
        if (lat == 0) begin
            resp_ready = 1'b1;
            repeat (2) @(negedge clock);
            return;
        end
        chk({tag, "_result"}, resp_result, exp_res);
        chk({tag, "_timeout"}, 32'(resp_timeout), 32'(exp_to));
        chk({tag, "_bus_zero_in_resp"},
            32'(ci_cin) | ci_a | ci_b | 32'(ci_start) | 32'(req_ready), 32'd0);
        held_res = resp_result;
        held_to  = resp_timeout;
        for (int h = 1; h <= hold; h++) begin
            @(negedge clock);
            if (resp_valid !== 1'b1 || resp_result !== held_res || resp_timeout !== held_to ||
                req_ready !== 1'b0 || ci_start !== 1'b0) bad_stab++;
        end
        if (hold > 0) chk({tag, "_resp_hold_stable"}, 32'(bad_stab), 32'd0);
        resp_ready = 1'b1;
        @(negedge clock);
        chk({tag, "_back_to_idle"}, {30'd0, resp_valid, req_ready}, 32'd1);
        $display("op %s: sel4=%0b cin=%0d a=%08h b=%08h lat=%0d result=%08h timeout=%0b",
                 tag, s4, cin, a, b, lat, held_res, held_to);
    endtask

    typedef struct {
        logic        s4;
        logic [7:0]  cin;
        logic [31:0] a;
        logic [31:0] b;
        int          mode;
        int          delay;
        int          hold;
        int          exp_lat;
        logic [31:0] exp_res;
        logic        exp_to;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{1'b0, 8'd30, 32'h2811_1113, 32'd0,         0, 0,  0, 2,  32'h0000_0002, 1'b0};
        vecs[1] = '{1'b0, 8'd30, 32'h1234_5678, 32'h9ABC_DEF0, 2, 3,  0, 5,  32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1'b0, 8'd47, 32'h0000_1111, 32'h0000_2222, 0, 0,  0, 18, 32'h0000_0000, 1'b1};
        vecs[3] = '{1'b0, 8'd30, 32'h0000_0510, 32'd0,         0, 1,  5, 3,  32'h0000_000B, 1'b0};
        vecs[4] = '{1'b1, 8'd30, 32'h0000_0100, 32'h0000_0023, 1, 4,  0, 6,  32'h0000_0123, 1'b0};
        vecs[5] = '{1'b1, 8'd30, 32'h0000_0100, 32'h0000_0023, 1, 5,  0, 6,  32'h0000_0000, 1'b1};
        vecs[6] = '{1'b1, 8'd30, 32'h0000_0007, 32'h0000_0008, 1, 0,  0, 2,  32'h0000_000F, 1'b0};
        vecs[7] = '{1'b0, 8'd30, 32'h0BAD_F00D, 32'h1,         2, 16, 1, 18, 32'hDEAD_BEEF, 1'b0};
        vecs[8] = '{1'b0, 8'd30, 32'h0BAD_F00D, 32'h1,         2, 17, 0, 18, 32'h0000_0000, 1'b1};

        // Outputs while held in reset
        #2;
        chk("reset_req_ready", 32'(req_ready_w), 32'd0);
        chk("reset_ci_start", 32'(ci_start_w), 32'd0);
        chk("reset_ci_bus", 32'(ci_cin_w[0]) | ci_a_w[0] | ci_b_w[0] |
                            32'(ci_cin_w[1]) | ci_a_w[1] | ci_b_w[1], 32'd0);
        chk("reset_resp", 32'(resp_valid_w) | 32'(resp_timeout_w) |
                          resp_result_w[0] | resp_result_w[1], 32'd0);
        repeat (2) @(negedge clock);
        nReset = 1'b1;
        @(negedge clock);
        chk("ready_after_release", 32'(req_ready_w), 32'd3);

        // Directed table
        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].s4, vecs[i].cin, vecs[i].a, vecs[i].b,
                   vecs[i].mode, vecs[i].delay, vecs[i].hold,
                   vecs[i].exp_lat, vecs[i].exp_res, vecs[i].exp_to);
        end

        // Spurious done while idle
        sel4 = 1'b0;
        spur_done = 1'b1;
        @(negedge clock);
        spur_done = 1'b0;
        chk("spurious_done_idle", {29'd0, ci_start, resp_valid, req_ready}, 32'd1);
        @(negedge clock);
        chk("spurious_done_after", {29'd0, ci_start, resp_valid, req_ready}, 32'd1);

        // Reset during WAIT cycle 3 (cycle 4 relative to accept)
        sel4 = 1'b0; rsp_delay = 0; rsp_mode = 0; rsp_kill = 1'b0;
        req_cin = 8'd47; req_a = 32'hCAFE_0001; req_b = 32'hCAFE_0002; req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("wait3_bus_live", 32'(ci_cin), 32'd47);
        nReset = 1'b0;
        #1;
        chk("midreset_ready_start", {30'd0, req_ready, ci_start}, 32'd0);
        chk("midreset_bus", 32'(ci_cin) | ci_a | ci_b, 32'd0);
        chk("midreset_resp", 32'(resp_valid) | 32'(resp_timeout) | resp_result, 32'd0);
        @(negedge clock);
        nReset = 1'b1;
        rsp_kill = 1'b1;
        @(negedge clock);
        chk("ready_after_midreset", 32'(req_ready), 32'd1);
        begin
            int ghost;
            ghost = 0;
            for (int c = 0; c < 20; c++) begin
                if (resp_valid !== 1'b0 || ci_start !== 1'b0) ghost++;
                @(negedge clock);
            end
            chk("no_resp_after_reset", 32'(ghost), 32'd0);
        end
        run_op("post_reset", 1'b0, 8'd30, 32'h0000_3010, 32'd0, 0, 2, 0,
               4, 32'h0000_0020, 1'b0);

        // Randomized traffic against the reference model
        for (int t = 0; t < 40; t++) begin
            logic        s4, to;
            logic [7:0]  cin;
            logic [31:0] a, b, res;
            int          mode, delay, hold, lat;
            s4    = 1'($urandom_range(0, 1));
            cin   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : RSP_ID;
            a     = $urandom;
            b     = $urandom;
            mode  = int'($urandom_range(0, 2));
            delay = int'($urandom_range(0, s4 ? 6 : 19));
            hold  = int'($urandom_range(0, 3));
            model(s4, cin, a, b, mode, delay, lat, res, to);
            run_op($sformatf("rnd%0d", t), s4, cin, a, b, mode, delay, hold, lat, res, to);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
